// File: rtl/rom_port_arbiter_pkg.sv
// Shared types and constants for the ROM/RAM port arbiter: FSM states,
// access owners and grant-vector bit positions.
package rom_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACC_RD,
        ST_ACC_WR,
        ST_RESP
    } state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LD,
        OWN_CPU,
        OWN_BLT
    } owner_t;

    localparam int unsigned NUM_PORTS   = 3;
    localparam int unsigned GNT_LD      = 0;
    localparam int unsigned GNT_CPU     = 1;
    localparam int unsigned GNT_BLT     = 2;
    localparam int unsigned BURST_CNT_W = 4;

endpackage

// File: rtl/rom_port_arbiter_picker.sv
// Priority select for the three requesters plus the blitter starvation guard;
// produces a one-hot grant whenever arb_en_i is high.
module rom_arb_picker
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned BLIT_BURST_MAX = 4
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 arb_en_i,
    input  logic                 boot_done_i,
    input  logic [NUM_PORTS-1:0] req_i,
    output logic [NUM_PORTS-1:0] gnt_o
);

    logic [BURST_CNT_W-1:0] burst_q, burst_d;
    logic                   cpu_force;

    assign cpu_force = req_i[GNT_CPU] && (burst_q >= BURST_CNT_W'(BLIT_BURST_MAX));

    always_comb begin
        gnt_o = '0;
        if (arb_en_i) begin
            if (!boot_done_i) begin
                if (req_i[GNT_LD])       gnt_o[GNT_LD]  = 1'b1;
                else if (cpu_force)      gnt_o[GNT_CPU] = 1'b1;
                else if (req_i[GNT_BLT]) gnt_o[GNT_BLT] = 1'b1;
                else if (req_i[GNT_CPU]) gnt_o[GNT_CPU] = 1'b1;
            end else begin
                if (cpu_force)           gnt_o[GNT_CPU] = 1'b1;
                else if (req_i[GNT_BLT]) gnt_o[GNT_BLT] = 1'b1;
                else if (req_i[GNT_CPU]) gnt_o[GNT_CPU] = 1'b1;
                else if (req_i[GNT_LD])  gnt_o[GNT_LD]  = 1'b1;
            end
        end
    end

    // Counts blitter grants only while the CPU is actually waiting.
    always_comb begin
        burst_d = burst_q;
        if (!req_i[GNT_CPU] || gnt_o[GNT_CPU]) begin
            burst_d = '0;
        end else if (gnt_o[GNT_BLT]) begin
            burst_d = burst_q + 1'b1;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            burst_q <= '0;
        end else begin
            burst_q <= burst_d;
        end
    end

endmodule

// File: rtl/rom_port_arbiter.sv
// Arbiter sharing the single-port ROM/RAM store between loader, CPU and blitter.
// Optional write lock after boot: define ROM_WRITE_LOCK_EN.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W         = 16,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned BLIT_BURST_MAX = 4
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              ld_req_i,
    input  logic [ADDR_W-1:0] ld_addr_i,
    input  logic [DATA_W-1:0] ld_data_i,
    input  logic              ld_done_i,
    output logic              ld_ack_o,
    input  logic              cpu_req_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    output logic              cpu_ack_o,
    output logic [DATA_W-1:0] cpu_rdata_o,
    output logic              cpu_rvalid_o,
    input  logic              blt_req_i,
    input  logic [ADDR_W-1:0] blt_addr_i,
    output logic              blt_ack_o,
    output logic [DATA_W-1:0] blt_rdata_o,
    output logic              blt_rvalid_o,
    output logic [ADDR_W-1:0] mem_address_o,
    output logic              mem_write_enable_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic              busy_o,
    output logic              wr_error_o
);

    state_t              state_q, state_d;
    owner_t              owner_q, owner_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                wr_lock_q, wr_lock_d;
    logic                boot_done_q;
    logic [DATA_W-1:0]   cpu_rdata_q, blt_rdata_q;
    logic                cpu_rvalid_q, blt_rvalid_q;
    logic                arb_en;
    logic                lock_active;
    logic                cpu_rd_done, blt_rd_done;
    logic [NUM_PORTS-1:0] req, gnt;

    assign arb_en = (state_q != ST_ACC_RD);
    assign req    = {blt_req_i, cpu_req_i, ld_req_i};

    rom_arb_picker #(
        .BLIT_BURST_MAX(BLIT_BURST_MAX)
    ) u_picker (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .arb_en_i   (arb_en),
        .boot_done_i(boot_done_q),
        .req_i      (req),
        .gnt_o      (gnt)
    );

`ifdef ROM_WRITE_LOCK_EN
    logic wr_error_q;

    assign lock_active = boot_done_q;
    assign wr_error_o  = wr_error_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            wr_error_q <= 1'b0;
        end else if (state_q == ST_ACC_WR && wr_lock_q) begin
            wr_error_q <= 1'b1;
        end
    end
`else
    assign lock_active = 1'b0;
    assign wr_error_o  = 1'b0;
`endif

    // Requesters present their next request during the ack cycle, so the
    // arbitration done in ACC_WR/RESP already sees the following transfer.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        wr_lock_d   = wr_lock_q;
        if (state_q == ST_ACC_RD) begin
            state_d = ST_RESP;
        end else begin
            state_d = ST_IDLE;
            owner_d = OWN_NONE;
            if (gnt[GNT_LD]) begin
                state_d     = ST_ACC_WR;
                owner_d     = OWN_LD;
                mem_addr_d  = ld_addr_i;
                mem_wdata_d = ld_data_i;
                wr_lock_d   = lock_active;
            end else if (gnt[GNT_CPU]) begin
                state_d    = ST_ACC_RD;
                owner_d    = OWN_CPU;
                mem_addr_d = cpu_addr_i;
            end else if (gnt[GNT_BLT]) begin
                state_d    = ST_ACC_RD;
                owner_d    = OWN_BLT;
                mem_addr_d = blt_addr_i;
            end
        end
    end

    assign cpu_rd_done = (state_q == ST_RESP) && (owner_q == OWN_CPU);
    assign blt_rd_done = (state_q == ST_RESP) && (owner_q == OWN_BLT);

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_NONE;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            wr_lock_q    <= 1'b0;
            boot_done_q  <= 1'b0;
            cpu_rdata_q  <= '0;
            blt_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
            blt_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            wr_lock_q    <= wr_lock_d;
            boot_done_q  <= boot_done_q | ld_done_i;
            cpu_rvalid_q <= cpu_rd_done;
            blt_rvalid_q <= blt_rd_done;
            if (cpu_rd_done) cpu_rdata_q <= mem_data_i;
            if (blt_rd_done) blt_rdata_q <= mem_data_i;
        end
    end

    assign ld_ack_o           = (state_q == ST_ACC_WR);
    assign cpu_ack_o          = (state_q == ST_ACC_RD) && (owner_q == OWN_CPU);
    assign blt_ack_o          = (state_q == ST_ACC_RD) && (owner_q == OWN_BLT);
    assign mem_write_enable_o = (state_q == ST_ACC_WR) && !wr_lock_q;
    assign mem_address_o      = mem_addr_q;
    assign mem_data_o         = mem_wdata_q;
    assign cpu_rdata_o        = cpu_rdata_q;
    assign blt_rdata_o        = blt_rdata_q;
    assign cpu_rvalid_o       = cpu_rvalid_q;
    assign blt_rvalid_o       = blt_rvalid_q;
    assign busy_o             = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Self-checking bench for rom_port_arbiter with a 64Kx8 word-organised memory stub.
// Expectations follow ROM_WRITE_LOCK_EN when defined for the build.
module tb_rom_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        ld_req, ld_done, ld_ack;
    logic [15:0] ld_addr;
    logic [7:0]  ld_data;
    logic        cpu_req, cpu_ack, cpu_rvalid;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_rdata;
    logic        blt_req, blt_ack, blt_rvalid;
    logic [15:0] blt_addr;
    logic [7:0]  blt_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata, mem_rdata;
    logic        busy, wr_error;

    rom_port_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .BLIT_BURST_MAX(4)
    ) dut (
        .clock_i(clk), .reset_i(rst),
        .ld_req_i(ld_req), .ld_addr_i(ld_addr), .ld_data_i(ld_data),
        .ld_done_i(ld_done), .ld_ack_o(ld_ack),
        .cpu_req_i(cpu_req), .cpu_addr_i(cpu_addr), .cpu_ack_o(cpu_ack),
        .cpu_rdata_o(cpu_rdata), .cpu_rvalid_o(cpu_rvalid),
        .blt_req_i(blt_req), .blt_addr_i(blt_addr), .blt_ack_o(blt_ack),
        .blt_rdata_o(blt_rdata), .blt_rvalid_o(blt_rvalid),
        .mem_address_o(mem_addr), .mem_write_enable_o(mem_we),
        .mem_data_o(mem_wdata), .mem_data_i(mem_rdata),
        .busy_o(busy), .wr_error_o(wr_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory stub: 16-bit words, registered read, byte lane from live address bit 0.
    logic [15:0] mem_words [32768];
    logic [15:0] rword_q;
    always @(posedge clk) begin
        if (mem_we) begin
            if (mem_addr[0]) mem_words[mem_addr[15:1]][15:8] <= mem_wdata;
            else             mem_words[mem_addr[15:1]][7:0]  <= mem_wdata;
        end
        rword_q <= mem_words[mem_addr[15:1]];
    end
    assign mem_rdata = mem_addr[0] ? rword_q[15:8] : rword_q[7:0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic [7:0] cpu_exp_q [$];
    logic [7:0] blt_exp_q [$];
    int         cpu_ack_q [$];
    int         blt_ack_q [$];

    always @(negedge clk) begin
        if (rst) begin
            cpu_exp_q.delete(); blt_exp_q.delete();
            cpu_ack_q.delete(); blt_ack_q.delete();
        end else begin
            if (cpu_ack) cpu_ack_q.push_back(cyc);
            if (blt_ack) blt_ack_q.push_back(cyc);
            if (cpu_rvalid) begin
                if (cpu_exp_q.size() == 0 || cpu_ack_q.size() == 0) begin
                    check("cpu_unexpected_rvalid", 32'(1), 32'(0));
                end else begin
                    check("cpu_rdata", 32'(cpu_rdata), 32'(cpu_exp_q.pop_front()));
                    check("cpu_rvalid_latency", 32'(cyc - cpu_ack_q.pop_front()), 32'(2));
                end
            end
            if (blt_rvalid) begin
                if (blt_exp_q.size() == 0 || blt_ack_q.size() == 0) begin
                    check("blt_unexpected_rvalid", 32'(1), 32'(0));
                end else begin
                    check("blt_rdata", 32'(blt_rdata), 32'(blt_exp_q.pop_front()));
                    check("blt_rvalid_latency", 32'(cyc - blt_ack_q.pop_front()), 32'(2));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic cpu_start(input logic [15:0] a, input logic [7:0] e);
        cpu_exp_q.push_back(e);
        cpu_req  = 1'b1;
        cpu_addr = a;
    endtask

    task automatic blt_start(input logic [15:0] a, input logic [7:0] e);
        blt_exp_q.push_back(e);
        blt_req  = 1'b1;
        blt_addr = a;
    endtask

    task automatic cpu_wait(output int ack_cyc);
        bit got = 1'b0;
        ack_cyc = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            if (cpu_ack) got = 1'b1;
        end
        cpu_req = 1'b0;
        check("cpu_ack_seen", 32'(got), 32'(1));
        if (got) ack_cyc = cyc;
    endtask

    task automatic blt_wait(output int ack_cyc);
        bit got = 1'b0;
        ack_cyc = -1;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            if (blt_ack) got = 1'b1;
        end
        blt_req = 1'b0;
        check("blt_ack_seen", 32'(got), 32'(1));
        if (got) ack_cyc = cyc;
    endtask

    task automatic ld_write(input logic [15:0] a, input logic [7:0] d, input logic exp_we,
                            input logic last, output int ack_cyc);
        bit got = 1'b0;
        ack_cyc = -1;
        ld_req  = 1'b1;
        ld_addr = a;
        ld_data = d;
        for (int i = 0; i < 64 && !got; i++) begin
            tick();
            if (ld_ack) got = 1'b1;
        end
        check("ld_ack_seen", 32'(got), 32'(1));
        if (got) begin
            ack_cyc = cyc;
            check("ld_we", 32'(mem_we), 32'(exp_we));
            check("ld_mem_addr", 32'(mem_addr), 32'(a));
            check("ld_mem_data", 32'(mem_wdata), 32'(d));
        end
        if (last) ld_req = 1'b0;
    endtask

    typedef enum int { P_LD, P_CPU, P_BLT } port_e;
    typedef struct {
        port_e       port;
        logic [15:0] addr;
        logic [7:0]  data;   // write data, or expected read data
    } vec_t;

    vec_t vecs [11];

    initial begin
        int t0, t1, k, prev;
        logic [7:0] exp_lock_rd;
        logic       exp_lock_we, exp_lock_err;

        vecs[0]  = '{P_LD,  16'h0000, 8'hA5};
        vecs[1]  = '{P_LD,  16'h0001, 8'h5A};
        vecs[2]  = '{P_CPU, 16'h0001, 8'h5A};
        vecs[3]  = '{P_LD,  16'h8000, 8'hC3};
        vecs[4]  = '{P_LD,  16'h8001, 8'h3C};
        vecs[5]  = '{P_LD,  16'hFFFF, 8'h77};
        vecs[6]  = '{P_LD,  16'h0010, 8'h11};
        vecs[7]  = '{P_BLT, 16'h8000, 8'hC3};
        vecs[8]  = '{P_CPU, 16'hFFFF, 8'h77};
        vecs[9]  = '{P_BLT, 16'h0000, 8'hA5};
        vecs[10] = '{P_CPU, 16'h0010, 8'h11};

        rst = 1'b1; ld_req = 1'b0; ld_done = 1'b0; ld_addr = '0; ld_data = '0;
        cpu_req = 1'b0; cpu_addr = '0; blt_req = 1'b0; blt_addr = '0;
        idle(3);
        check("reset_outputs_zero",
              32'({busy, ld_ack, cpu_ack, blt_ack, cpu_rvalid, blt_rvalid, mem_we, wr_error}), 32'(0));
        check("reset_addr_data_zero", {mem_addr, mem_wdata, cpu_rdata ^ blt_rdata}, 32'(0));
        rst = 1'b0;
        idle(2);

        foreach (vecs[i]) begin
            case (vecs[i].port)
                P_LD:  ld_write(vecs[i].addr, vecs[i].data, 1'b1, 1'b1, t0);
                P_CPU: begin cpu_start(vecs[i].addr, vecs[i].data); cpu_wait(t0); end
                default: begin blt_start(vecs[i].addr, vecs[i].data); blt_wait(t0); end
            endcase
        end
        idle(6);

        // Same-cycle CPU and blitter requests: blitter first, CPU two cycles later.
        cpu_start(16'h8000, 8'hC3);
        blt_start(16'h8001, 8'h3C);
        blt_wait(t0);
        cpu_wait(t1);
        check("cpu_after_blt_gap", 32'(t1 - t0), 32'(2));
        idle(6);

        // Starvation guard: four blitter grants, then one CPU grant, repeating.
        blt_req = 1'b1; blt_addr = 16'h8001;
        cpu_req = 1'b1; cpu_addr = 16'h8000;
        k = 0;
        for (int i = 0; i < 120 && k < 10; i++) begin
            tick();
            if (blt_ack || cpu_ack) begin
                if (blt_ack) blt_exp_q.push_back(8'h3C);
                else         cpu_exp_q.push_back(8'hC3);
                check("burst_order_is_blt", 32'(blt_ack), 32'((k % 5) < 4));
                k++;
            end
        end
        blt_req = 1'b0; cpu_req = 1'b0;
        check("burst_ack_count", 32'(k), 32'(10));
        idle(6);

        // Pre-boot loader burst with the CPU waiting: one write per cycle.
        cpu_start(16'h0021, 8'h41);
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            ld_write(16'h0020 + 16'(i), 8'h40 + 8'(i), 1'b1, (i == 3), t0);
            check("ld_burst_cpu_held_off", 32'(cpu_ack), 32'(0));
            if (i > 0) check("ld_burst_every_cycle", 32'(t0 - prev), 32'(1));
            prev = t0;
        end
        cpu_wait(t1);
        check("cpu_after_ld_burst", 32'(t1 - prev), 32'(1));
        idle(6);

        // Reset while the CPU read is in its response cycle.
        cpu_start(16'h0000, 8'hA5);
        cpu_wait(t0);
        tick();
        rst = 1'b1;
        tick();
        check("reset_in_resp_outputs_zero",
              32'({busy, ld_ack, cpu_ack, blt_ack, cpu_rvalid, blt_rvalid, mem_we, wr_error}), 32'(0));
        check("reset_in_resp_addr_data_zero", {mem_addr, mem_wdata, cpu_rdata | blt_rdata}, 32'(0));
        idle(2);
        rst = 1'b0;
        idle(2);
        cpu_start(16'h0001, 8'h5A);
        cpu_wait(t0);
        idle(6);

        // Boot done, then a further loader write.
`ifdef ROM_WRITE_LOCK_EN
        exp_lock_we = 1'b0; exp_lock_err = 1'b1; exp_lock_rd = 8'h11;
`else
        exp_lock_we = 1'b1; exp_lock_err = 1'b0; exp_lock_rd = 8'hFF;
`endif
        ld_done = 1'b1;
        tick();
        ld_done = 1'b0;
        tick();
        ld_write(16'h0010, 8'hFF, exp_lock_we, 1'b1, t0);
        tick();
        check("wr_error_after_done", 32'(wr_error), 32'(exp_lock_err));
        cpu_start(16'h0010, exp_lock_rd);
        cpu_wait(t0);
        idle(8);
        check("wr_error_sticky", 32'(wr_error), 32'(exp_lock_err));

        check("cpu_scoreboard_drained", 32'(cpu_exp_q.size()), 32'(0));
        check("blt_scoreboard_drained", 32'(blt_exp_q.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got still running, required finished");
        $fatal(1, "timeout");
    end

endmodule
